// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared configuration for the register-file writeback arbiter: widths,
// writeback request record and grant bit positions.
package regfile_wb_arbiter_pkg;

  localparam int CFG_DATA_WIDTH   = 32;
  localparam int CFG_NUM_REGISTER = 32;
  localparam int CFG_ADDR_W       = $clog2(CFG_NUM_REGISTER);

  typedef struct packed {
    logic [CFG_ADDR_W-1:0]     addr;
    logic [CFG_DATA_WIDTH-1:0] data;
  } wb_req_t;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/regfile_wb_arbiter_wb_hold_buf.sv
// wb_hold_buf: one-entry valid/ready writeback holding buffer. Requests that
// target x0 complete the handshake but are never stored.
module regfile_wb_arbiter_wb_hold_buf
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = CFG_DATA_WIDTH,
  parameter int ADDR_W     = CFG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic                  grant,
  output logic                  load,
  output logic                  held,
  output logic [ADDR_W-1:0]     hold_addr,
  output logic [DATA_WIDTH-1:0] hold_data
);

  // A granted entry leaves on this edge, so its slot can be refilled at once.
  assign ready = ~held | grant;
  assign load  = valid & ready & (req_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held      <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else if (load) begin
      held      <= 1'b1;
      hold_addr <= req_addr;
      hold_data <= req_data;
    end else if (grant) begin
      held      <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Oldest-first arbiter sharing the register file write port between ALU and LSU.
// Optional saturating write/conflict counters behind REGFILE_WB_STATS_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH   = CFG_DATA_WIDTH,
  parameter int NUM_REGISTER = CFG_NUM_REGISTER,
  localparam int ADDR_W      = $clog2(NUM_REGISTER)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [ADDR_W-1:0]     alu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_rd_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_W-1:0]     lsu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_rd_data_i,
  output logic                  rf_we_o,
  output logic [ADDR_W-1:0]     rf_rd_addr_o,
  output logic [DATA_WIDTH-1:0] rf_rd_o,
  output logic [1:0]            grant_o
`ifdef REGFILE_WB_STATS_EN
  ,
  output logic [15:0]           stat_writes_o,
  output logic [15:0]           stat_conflict_o
`endif
);

  logic                  alu_held, lsu_held;
  logic                  alu_load, lsu_load;
  logic                  grant_alu, grant_lsu;
  logic [ADDR_W-1:0]     alu_addr, lsu_addr;
  logic [DATA_WIDTH-1:0] alu_data, lsu_data;
  logic                  older_is_lsu;
  logic                  alu_next_held, lsu_next_held;
  logic [1:0]            grant_next;

  regfile_wb_arbiter_wb_hold_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) u_alu_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .valid     (alu_valid_i),
    .ready     (alu_ready_o),
    .req_addr  (alu_rd_addr_i),
    .req_data  (alu_rd_data_i),
    .grant     (grant_alu),
    .load      (alu_load),
    .held      (alu_held),
    .hold_addr (alu_addr),
    .hold_data (alu_data)
  );

  regfile_wb_arbiter_wb_hold_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) u_lsu_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .valid     (lsu_valid_i),
    .ready     (lsu_ready_o),
    .req_addr  (lsu_rd_addr_i),
    .req_data  (lsu_rd_data_i),
    .grant     (grant_lsu),
    .load      (lsu_load),
    .held      (lsu_held),
    .hold_addr (lsu_addr),
    .hold_data (lsu_data)
  );

  always_comb begin
    grant_alu = alu_held & (~lsu_held | ~older_is_lsu);
    grant_lsu = lsu_held & (~alu_held | older_is_lsu);
    grant_next = 2'b00;
    grant_next[WB_SRC_ALU] = grant_alu;
    grant_next[WB_SRC_LSU] = grant_lsu;
    alu_next_held = alu_load | (alu_held & ~grant_alu);
    lsu_next_held = lsu_load | (lsu_held & ~grant_lsu);
  end

  // A fresh capture is always younger than a surviving entry; on a tie the LSU wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      older_is_lsu <= 1'b0;
    end else if (alu_next_held && lsu_next_held) begin
      if (alu_load)      older_is_lsu <= 1'b1;
      else if (lsu_load) older_is_lsu <= 1'b0;
    end else begin
      older_is_lsu <= lsu_next_held;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_we_o      <= 1'b0;
      rf_rd_addr_o <= '0;
      rf_rd_o      <= '0;
      grant_o      <= 2'b00;
    end else begin
      rf_we_o <= grant_alu | grant_lsu;
      grant_o <= grant_next;
      if (grant_lsu) begin
        rf_rd_addr_o <= lsu_addr;
        rf_rd_o      <= lsu_data;
      end else if (grant_alu) begin
        rf_rd_addr_o <= alu_addr;
        rf_rd_o      <= alu_data;
      end
    end
  end

`ifdef REGFILE_WB_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_writes_o   <= '0;
      stat_conflict_o <= '0;
    end else begin
      if (rf_we_o && stat_writes_o != STAT_MAX)
        stat_writes_o <= stat_writes_o + 16'd1;
      if (alu_held && lsu_held && stat_conflict_o != STAT_MAX)
        stat_conflict_o <= stat_conflict_o + 16'd1;
    end
  end
`endif

endmodule
